// File: rtl/fetch_queue_if.sv
// Handshake bundle between the fetch stage (master) and the fetch queue (slave).
// Carries both the enqueue side (IF -> queue) and the dequeue side (queue -> ID).
interface fetch_queue_if;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        in_br_pred;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_br_pred;

    modport master (
        output in_valid, in_instr, in_pc, in_br_pred, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_br_pred
    );

    modport slave (
        input  in_valid, in_instr, in_pc, in_br_pred, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_br_pred
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular FIFO between IF and ID with flush,
// NOP substitution when empty, and a saturating backpressure cycle counter.
module fetch_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          flush,
    fetch_queue_if.slave  q,
    output logic [4:0]    count,
    output logic [15:0]   bp_cycles
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc_mem    [DEPTH];
    logic          br_mem    [DEPTH];

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          bp_event;

    always_comb begin
        full     = (count == 5'(DEPTH));
        empty    = (count == '0);
        push     = q.in_valid && !full && !flush;
        pop      = !empty && q.out_ready && !flush;
        bp_event = q.in_valid && full && !flush;
    end

    // in_ready looks only at occupancy, so a full queue refuses a push even while popping.
    always_comb begin
        q.in_ready    = !full;
        q.out_valid   = !empty;
        q.out_instr   = NOP_INSTR;
        q.out_pc      = '0;
        q.out_br_pred = 1'b0;
        if (!empty) begin
            q.out_instr   = instr_mem[rd_ptr];
            q.out_pc      = pc_mem[rd_ptr];
            q.out_br_pred = br_mem[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + 5'd1;
            else if (pop && !push) count <= count - 5'd1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bp_cycles <= '0;
        end else if (bp_event && (bp_cycles != '1)) begin
            bp_cycles <= bp_cycles + 16'd1;
        end
    end

    // Storage holds no reset; the read mux above masks stale contents while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= q.in_instr;
            pc_mem[wr_ptr]    <= q.in_pc;
            br_mem[wr_ptr]    <= q.in_br_pred;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_fetch_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        br;
    } ent_t;

    logic        clk;
    logic        n_rst;
    logic        flush;
    logic [4:0]  count;
    logic [15:0] bp_cycles;

    fetch_queue_if fq ();

    fetch_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .flush     (flush),
        .q         (fq.slave),
        .count     (count),
        .bp_cycles (bp_cycles)
    );

    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 0;
    ent_t mq[$];
    int   mbp = 0;
    bit   m_full;
    bit   m_empty;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of entries and an occupancy-based rule set.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mq.delete();
            mbp = 0;
        end else if (flush) begin
            mq.delete();
        end else begin
            m_full  = (mq.size() == DEPTH);
            m_empty = (mq.size() == 0);
            if (fq.in_valid && m_full && mbp < 65535) mbp++;
            if (!m_empty && fq.out_ready) void'(mq.pop_front());
            if (fq.in_valid && !m_full) mq.push_back({fq.in_instr, fq.in_pc, fq.in_br_pred});
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("in_ready",  32'(fq.in_ready),  32'(mq.size() != DEPTH));
            chk("out_valid", 32'(fq.out_valid), 32'(mq.size() != 0));
            chk("count",     32'(count),        32'(mq.size()));
            chk("bp_cycles", 32'(bp_cycles),    32'(mbp));
            if (mq.size() != 0) begin
                chk("out_instr", fq.out_instr,        mq[0].instr);
                chk("out_pc",    fq.out_pc,           mq[0].pc);
                chk("out_br",    32'(fq.out_br_pred), 32'(mq[0].br));
            end else begin
                chk("out_instr_nop", fq.out_instr,        NOP);
                chk("out_pc_nop",    fq.out_pc,           32'h0);
                chk("out_br_nop",    32'(fq.out_br_pred), 32'h0);
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit v, input logic [31:0] pc);
        fq.in_valid   = v;
        fq.in_pc      = pc;
        fq.in_instr   = $urandom();
        fq.in_br_pred = 1'($urandom_range(0, 1));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_count"},     32'(count),           32'h0);
        chk({tag, "_bp"},        32'(bp_cycles),       32'h0);
        chk({tag, "_out_valid"}, 32'(fq.out_valid),    32'h0);
        chk({tag, "_in_ready"},  32'(fq.in_ready),     32'h1);
        chk({tag, "_out_instr"}, fq.out_instr,         NOP);
        chk({tag, "_out_pc"},    fq.out_pc,            32'h0);
        chk({tag, "_out_br"},    32'(fq.out_br_pred),  32'h0);
    endtask

    initial begin
        n_rst        = 1'b0;
        flush        = 1'b0;
        fq.out_ready = 1'b0;
        set_in(1'b0, 32'h0);
        #1;
        chk_reset_vals("por");
        #12 n_rst = 1'b1;
        step();
        cmp_en = 1;

        // Async reset mid-operation: reach count=2, bp_cycles=5 first.
        for (int unsigned i = 0; i < 4; i++) begin
            set_in(1'b1, 32'h300 + 32'(4 * i));
            step();
        end
        for (int unsigned i = 0; i < 5; i++) step();
        set_in(1'b0, 32'h0);
        fq.out_ready = 1'b1;
        step();
        step();
        fq.out_ready = 1'b0;
        chk("pre_rst_count", 32'(count),     32'h2);
        chk("pre_rst_bp",    32'(bp_cycles), 32'h5);
        #3 n_rst = 1'b0;
        #1;
        chk_reset_vals("async");
        #2 n_rst = 1'b1;
        set_in(1'b1, 32'h200);
        step();
        set_in(1'b0, 32'h0);
        chk("post_rst_head", fq.out_pc, 32'h200);
        fq.out_ready = 1'b1;
        step();
        fq.out_ready = 1'b0;

        // Fill then drain in order.
        for (int unsigned i = 0; i < 4; i++) begin
            set_in(1'b1, 32'(4 * i));
            step();
        end
        set_in(1'b0, 32'h0);
        chk("fill_count", 32'(count),       32'h4);
        chk("fill_ready", 32'(fq.in_ready), 32'h0);
        fq.out_ready = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            chk("drain_pc", fq.out_pc, 32'(4 * i));
            step();
        end
        chk("drain_nop", fq.out_instr, NOP);

        // Full queue with a pop: push is refused, bp_cycles ticks once.
        fq.out_ready = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            set_in(1'b1, 32'h80 + 32'(4 * i));
            step();
        end
        begin
            logic [15:0] bp0;
            bp0 = bp_cycles;
            fq.out_ready = 1'b1;
            step();
            set_in(1'b0, 32'h0);
            chk("fullpop_count", 32'(count),     32'h3);
            chk("fullpop_bp",    32'(bp_cycles), 32'(bp0 + 16'd1));
            chk("fullpop_head",  fq.out_pc,      32'h84);
        end
        for (int unsigned i = 0; i < 3; i++) step();

        // Wrap-around at steady occupancy 2.
        fq.out_ready = 1'b0;
        for (int unsigned i = 0; i < 2; i++) begin
            set_in(1'b1, 32'h100 + 32'(4 * i));
            step();
        end
        fq.out_ready = 1'b1;
        for (int unsigned j = 0; j < 10; j++) begin
            set_in(1'b1, 32'h100 + 32'(4 * (j + 2)));
            chk("wrap_pc", fq.out_pc, 32'h100 + 32'(4 * j));
            step();
        end
        set_in(1'b0, 32'h0);
        chk("wrap_count", 32'(count), 32'h2);
        step();
        step();

        // Flush with concurrent push and pop.
        fq.out_ready = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            set_in(1'b1, 32'h500 + 32'(4 * i));
            step();
        end
        flush = 1'b1;
        fq.out_ready = 1'b1;
        step();
        flush = 1'b0;
        set_in(1'b0, 32'h0);
        chk("flush_count", 32'(count),        32'h0);
        chk("flush_valid", 32'(fq.out_valid), 32'h0);
        chk("flush_instr", fq.out_instr,      NOP);
        fq.out_ready = 1'b0;
        set_in(1'b1, 32'h40);
        step();
        set_in(1'b0, 32'h0);
        chk("flush_next_head", fq.out_pc, 32'h40);
        fq.out_ready = 1'b1;
        step();

        // Randomized traffic with occasional flush.
        for (int unsigned i = 0; i < 3000; i++) begin
            set_in(1'($urandom_range(0, 99) < 60), $urandom());
            fq.out_ready = 1'($urandom_range(0, 99) < 50);
            flush        = 1'($urandom_range(0, 99) < 3);
            step();
        end
        flush = 1'b0;

        // Saturation of the backpressure counter.
        fq.out_ready = 1'b0;
        for (int unsigned i = 0; i < 70000; i++) begin
            set_in(1'b1, 32'h900 + 32'(i));
            step();
        end
        chk("sat_bp", 32'(bp_cycles), 32'hFFFF);
        step();
        step();
        chk("sat_hold", 32'(bp_cycles), 32'hFFFF);
        set_in(1'b0, 32'h0);
        step();
        cmp_en = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
